centroid_div_sequencer: RTL and testbench
=========================================

CENTROID_DIV_SEQUENCER -- requirements
Module: centroid_div_sequencer

Interface
REQ-001 SHALL have parameter X_WIDTH, default 10, x coordinate width.
REQ-002 SHALL have parameter Y_WIDTH, default 10, y coordinate width.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, accumulator, count and divider width (legal range 24..32).
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port frame_valid  input  1  high during active frame.
REQ-007 SHALL have port pixel_valid  input  1  pixel qualifier.
REQ-008 SHALL have port x  input  X_WIDTH  pixel column.
REQ-009 SHALL have port y  input  Y_WIDTH  pixel row.
REQ-010 SHALL have port object_pixel  input  1  pixel belongs to object.
REQ-011 SHALL have port min_count  input  ACC_WIDTH  minimum object pixels for a valid detection; sampled at the frame-end cycle.
REQ-012 SHALL have port centroid_x  output  X_WIDTH  registered centroid column.
REQ-013 SHALL have port centroid_y  output  Y_WIDTH  registered centroid row.
REQ-014 SHALL have port pixel_count  output  ACC_WIDTH  object pixel count of last completed frame.
REQ-015 SHALL have port centroid_valid  output  1  one-cycle result pulse.
REQ-016 SHALL have port object_found  output  1  last result met min_count.
REQ-017 SHALL have port busy  output  1  high while the FSM is not in IDLE.
REQ-018 SHALL have port frame_overrun  output  1  one-cycle pulse when a frame end is dropped.

Function
REQ-019 Accumulators sum_x, sum_y, cnt SHALL clear in every cycle frame_valid is low.
REQ-020 While frame_valid high, pixel_valid AND object_pixel SHALL add x, y (zero-extended) to sum_x, sum_y and increment cnt; other cycles hold.
REQ-021 Frame end (cycle E) SHALL be the first cycle with registered previous frame_valid=1 and current frame_valid=0.
REQ-022 At E in IDLE, sum_x, sum_y, cnt and min_count SHALL be copied into snapshot registers; accumulation continues independently thereafter.
REQ-023 FSM states SHALL be IDLE, DIV_X, DIV_Y, DONE.
REQ-024 IDLE->DIV_X at E when snapshot cnt >= min_count and cnt != 0; otherwise IDLE->DONE (no-object path).
REQ-025 One shared restoring divider, 1 quotient bit per cycle, SHALL compute sum_x/cnt in DIV_X (ACC_WIDTH cycles), then sum_y/cnt in DIV_Y (ACC_WIDTH cycles); quotient truncated toward zero.
REQ-026 DONE SHALL last one cycle, then return to IDLE; centroid_valid high only during DONE.
REQ-027 Object path: centroid_valid at cycle E+2*ACC_WIDTH+1 (E+65 at default); centroid_x/y = low bits of quotients, object_found=1, pixel_count=snapshot cnt; all updated on entry to DONE.
REQ-028 No-object path: centroid_valid at E+1; object_found=0; pixel_count=snapshot cnt; centroid_x/y hold previous values.
REQ-029 Frame end while busy=1 SHALL NOT disturb the running division; that frame's data is discarded and frame_overrun pulses at E'.
REQ-030 Frame end in the DONE cycle SHALL be treated as busy (discarded, overrun pulse).
REQ-031 Quotient width always fits X_WIDTH/Y_WIDTH since sum <= cnt*max coordinate; no saturation logic required.
REQ-032 min_count=0 with cnt=0 SHALL take the no-object path (no divide by zero).

Reset
REQ-033 rst_n low SHALL asynchronously force FSM to IDLE and clear accumulators, snapshots, divider, centroid_x, centroid_y, pixel_count, centroid_valid, object_found, busy, frame_overrun to 0, including mid-division; no pulse is emitted for an interrupted frame.

Verification
REQ-034 One object pixel (100,50), min_count=1, frame end at E -> E+65: centroid_valid=1, centroid (100,50), pixel_count=1, object_found=1.
REQ-035 Pixels (10,20),(11,20),(13,21) -> centroid (11,20), pixel_count=3; object_pixel=1 with pixel_valid=0 ignored.
REQ-036 Empty frame after REQ-034 result, min_count=1 -> E+1 pulse, object_found=0, centroid stays (100,50), pixel_count=0.
REQ-037 Two object pixels, min_count=5 -> no-object path, pulse at E+1, pixel_count=2.
REQ-038 Second frame end at E+10 -> frame_overrun pulse at E+10, first result unchanged at E+65, no second pulse.
REQ-039 rst_n low at E+20 -> all outputs 0 immediately, FSM IDLE, no centroid_valid until next frame end.

Source files
------------

// File: rtl/centroid_div_sequencer.sv
// Object centroid engine: accumulates object pixel coordinates per frame and
// divides the sums by the pixel count with one shared restoring divider.
module centroid_div_sequencer #(
  parameter int X_WIDTH   = 10,
  parameter int Y_WIDTH   = 10,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_valid,
  input  logic                 pixel_valid,
  input  logic [X_WIDTH-1:0]   x,
  input  logic [Y_WIDTH-1:0]   y,
  input  logic                 object_pixel,
  input  logic [ACC_WIDTH-1:0] min_count,
  output logic [X_WIDTH-1:0]   centroid_x,
  output logic [Y_WIDTH-1:0]   centroid_y,
  output logic [ACC_WIDTH-1:0] pixel_count,
  output logic                 centroid_valid,
  output logic                 object_found,
  output logic                 busy,
  output logic                 frame_overrun
);

  localparam int CW = $clog2(ACC_WIDTH);

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic                  r_fvPrev;
  logic [ACC_WIDTH-1:0]  r_sumX, r_sumY, r_cnt;
  logic [ACC_WIDTH-1:0]  r_snapSumY, r_snapCnt;
  logic [ACC_WIDTH-1:0]  r_rem, r_quo;
  logic [CW-1:0]         r_bitCnt;
  logic [X_WIDTH-1:0]    r_quoX;
  logic [X_WIDTH-1:0]    r_centroidX;
  logic [Y_WIDTH-1:0]    r_centroidY;
  logic [ACC_WIDTH-1:0]  r_pixelCount;
  logic                  r_objectFound;

  logic                  w_frameEnd;
  logic                  w_accept;
  logic                  w_hasObject;
  logic                  w_lastBit;
  logic                  w_dividing;
  logic [ACC_WIDTH:0]    w_shift;
  logic                  w_ge;
  logic [ACC_WIDTH-1:0]  w_diff;
  logic [ACC_WIDTH-1:0]  w_remNext;
  logic [ACC_WIDTH-1:0]  w_quoNext;

  assign w_frameEnd  = r_fvPrev && !frame_valid;
  assign w_accept    = w_frameEnd && (r_state == IDLE);
  assign w_hasObject = (r_cnt != '0) && (r_cnt >= min_count);
  assign w_lastBit   = (r_bitCnt == CW'(ACC_WIDTH - 1));
  assign w_dividing  = (r_state == DIV_X) || (r_state == DIV_Y);

  // Restoring step: the remainder after a successful subtract is below the
  // divisor, so only the low ACC_WIDTH bits of the difference are needed.
  assign w_shift   = {r_rem, r_quo[ACC_WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_snapCnt});
  assign w_diff    = w_shift[ACC_WIDTH-1:0] - r_snapCnt;
  assign w_remNext = w_ge ? w_diff : w_shift[ACC_WIDTH-1:0];
  assign w_quoNext = {r_quo[ACC_WIDTH-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState    = r_state;
    centroid_valid = 1'b0;
    busy           = (r_state != IDLE);
    frame_overrun  = w_frameEnd && (r_state != IDLE);
    case (r_state)
      IDLE:  if (w_frameEnd) w_nextState = w_hasObject ? DIV_X : DONE;
      DIV_X: if (w_lastBit)  w_nextState = DIV_Y;
      DIV_Y: if (w_lastBit)  w_nextState = DONE;
      DONE: begin
        centroid_valid = 1'b1;
        w_nextState    = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fvPrev      <= 1'b0;
      r_sumX        <= '0;
      r_sumY        <= '0;
      r_cnt         <= '0;
      r_snapSumY    <= '0;
      r_snapCnt     <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_bitCnt      <= '0;
      r_quoX        <= '0;
      r_centroidX   <= '0;
      r_centroidY   <= '0;
      r_pixelCount  <= '0;
      r_objectFound <= 1'b0;
    end else begin
      r_fvPrev <= frame_valid;
      if (!frame_valid) begin
        r_sumX <= '0;
        r_sumY <= '0;
        r_cnt  <= '0;
      end else if (pixel_valid && object_pixel) begin
        r_sumX <= r_sumX + {{(ACC_WIDTH-X_WIDTH){1'b0}}, x};
        r_sumY <= r_sumY + {{(ACC_WIDTH-Y_WIDTH){1'b0}}, y};
        r_cnt  <= r_cnt + ACC_WIDTH'(1);
      end

      if (w_accept) begin
        r_snapSumY <= r_sumY;
        r_snapCnt  <= r_cnt;
        r_quo      <= r_sumX;
        r_rem      <= '0;
        r_bitCnt   <= '0;
        if (!w_hasObject) begin
          r_pixelCount  <= r_cnt;
          r_objectFound <= 1'b0;
        end
      end else if (w_dividing) begin
        r_quo    <= w_quoNext;
        r_rem    <= w_remNext;
        r_bitCnt <= r_bitCnt + CW'(1);
        // The x quotient is parked while the same divider is reloaded with sum_y.
        if (w_lastBit && (r_state == DIV_X)) begin
          r_quoX   <= w_quoNext[X_WIDTH-1:0];
          r_quo    <= r_snapSumY;
          r_rem    <= '0;
          r_bitCnt <= '0;
        end else if (w_lastBit) begin
          r_centroidX   <= r_quoX;
          r_centroidY   <= w_quoNext[Y_WIDTH-1:0];
          r_pixelCount  <= r_snapCnt;
          r_objectFound <= 1'b1;
        end
      end
    end
  end

  assign centroid_x   = r_centroidX;
  assign centroid_y   = r_centroidY;
  assign pixel_count  = r_pixelCount;
  assign object_found = r_objectFound;

endmodule

// File: tb/tb_centroid_div_sequencer.sv
// Self-checking bench for centroid_div_sequencer: table-driven frames with a
// result scoreboard, plus hand-written overrun and reset sequences.
module tb_centroid_div_sequencer;

  localparam int XW  = 10;
  localparam int YW  = 10;
  localparam int AW  = 32;
  localparam int LAT = 2 * AW + 1;

  logic          clk;
  logic          rst_n;
  logic          frame_valid;
  logic          pixel_valid;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          object_pixel;
  logic [AW-1:0] min_count;
  logic [XW-1:0] centroid_x;
  logic [YW-1:0] centroid_y;
  logic [AW-1:0] pixel_count;
  logic          centroid_valid;
  logic          object_found;
  logic          busy;
  logic          frame_overrun;

  typedef struct {
    logic [0:3][XW-1:0] px;
    logic [0:3][YW-1:0] py;
    logic [0:3]         pObj;
    logic [0:3]         pPv;
    int                 nPix;
    logic [AW-1:0]      minCount;
    logic               expFound;
    logic [XW-1:0]      expX;
    logic [YW-1:0]      expY;
    logic [AW-1:0]      expCount;
  } frameVec_t;

  typedef struct {
    int            cyc;
    logic          found;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic [AW-1:0] cnt;
  } expRes_t;

  frameVec_t vecs[7];
  expRes_t   resQ[$];
  int        ovrQ[$];
  expRes_t   monRes;
  int        checks   = 0;
  int        failures = 0;
  int        cycleNum = 0;
  int        frameEnd;

  centroid_div_sequencer #(.X_WIDTH(XW), .Y_WIDTH(YW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .pixel_valid(pixel_valid),
    .x(x), .y(y), .object_pixel(object_pixel), .min_count(min_count),
    .centroid_x(centroid_x), .centroid_y(centroid_y), .pixel_count(pixel_count),
    .centroid_valid(centroid_valid), .object_found(object_found), .busy(busy),
    .frame_overrun(frame_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleNum = cycleNum + 1;

  task automatic checkOutput(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cycleNum);
    end
  endtask

  task automatic applyStimulus(input logic fv, input logic pv, input logic obj,
                               input logic [XW-1:0] xi, input logic [YW-1:0] yi);
    @(posedge clk);
    #1;
    frame_valid  = fv;
    pixel_valid  = pv;
    object_pixel = obj;
    x            = xi;
    y            = yi;
  endtask

  task automatic pushResult(input int cyc, input logic found, input logic [XW-1:0] cx,
                            input logic [YW-1:0] cy, input logic [AW-1:0] cnt);
    expRes_t e;
    e.cyc = cyc; e.found = found; e.cx = cx; e.cy = cy; e.cnt = cnt;
    resQ.push_back(e);
  endtask

  task automatic waitResults();
    int n = 0;
    while (resQ.size() != 0 && n < 300) begin
      applyStimulus(0, 0, 0, '0, '0);
      n++;
    end
    checkOutput("resultDrained", resQ.size(), 0);
  endtask

  task automatic runVec(input frameVec_t v);
    min_count = v.minCount;
    applyStimulus(1, 0, 0, '0, '0);
    for (int i = 0; i < v.nPix; i++)
      applyStimulus(1, v.pPv[i], v.pObj[i], v.px[i], v.py[i]);
    applyStimulus(0, 0, 0, '0, '0);
    pushResult(cycleNum + (v.expFound ? LAT : 1), v.expFound, v.expX, v.expY, v.expCount);
    waitResults();
    repeat (2) applyStimulus(0, 0, 0, '0, '0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_centroidX"}, centroid_x, 0);
    checkOutput({tag, "_centroidY"}, centroid_y, 0);
    checkOutput({tag, "_pixelCount"}, pixel_count, 0);
    checkOutput({tag, "_valid"}, centroid_valid, 0);
    checkOutput({tag, "_found"}, object_found, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_overrun"}, frame_overrun, 0);
  endtask

  // Scoreboard side: every result pulse and overrun pulse must be expected.
  always @(negedge clk) begin
    if (rst_n) begin
      if (centroid_valid) begin
        if (resQ.size() == 0) checkOutput("unexpectedValid", centroid_valid, 0);
        else begin
          monRes = resQ.pop_front();
          checkOutput("validCycle", cycleNum, monRes.cyc);
          checkOutput("centroidX", centroid_x, monRes.cx);
          checkOutput("centroidY", centroid_y, monRes.cy);
          checkOutput("pixelCount", pixel_count, monRes.cnt);
          checkOutput("objectFound", object_found, monRes.found);
        end
      end
      if (frame_overrun) begin
        if (ovrQ.size() == 0) checkOutput("unexpectedOverrun", frame_overrun, 0);
        else checkOutput("overrunCycle", cycleNum, ovrQ.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{'{10'd100, 10'd0, 10'd0, 10'd0}, '{10'd50, 10'd0, 10'd0, 10'd0},
                4'b1000, 4'b1000, 1, 32'd1, 1'b1, 10'd100, 10'd50, 32'd1};
    vecs[1] = '{'{10'd0, 10'd0, 10'd0, 10'd0}, '{10'd0, 10'd0, 10'd0, 10'd0},
                4'b0000, 4'b0000, 0, 32'd1, 1'b0, 10'd100, 10'd50, 32'd0};
    vecs[2] = '{'{10'd10, 10'd500, 10'd11, 10'd13}, '{10'd20, 10'd500, 10'd20, 10'd21},
                4'b1111, 4'b1011, 4, 32'd3, 1'b1, 10'd11, 10'd20, 32'd3};
    vecs[3] = '{'{10'd5, 10'd6, 10'd0, 10'd0}, '{10'd5, 10'd6, 10'd0, 10'd0},
                4'b1100, 4'b1100, 2, 32'd5, 1'b0, 10'd11, 10'd20, 32'd2};
    vecs[4] = '{'{10'd1023, 10'd0, 10'd300, 10'd0}, '{10'd1023, 10'd0, 10'd300, 10'd0},
                4'b1100, 4'b1110, 3, 32'd2, 1'b1, 10'd511, 10'd511, 32'd2};
    vecs[5] = '{'{10'd0, 10'd0, 10'd0, 10'd0}, '{10'd0, 10'd0, 10'd0, 10'd0},
                4'b0000, 4'b0000, 0, 32'd0, 1'b0, 10'd511, 10'd511, 32'd0};
    vecs[6] = '{'{10'd7, 10'd8, 10'd0, 10'd0}, '{10'd3, 10'd4, 10'd0, 10'd0},
                4'b1100, 4'b1100, 2, 32'd0, 1'b1, 10'd7, 10'd3, 32'd2};

    rst_n = 1'b0;
    frame_valid = 1'b0; pixel_valid = 1'b0; object_pixel = 1'b0;
    x = '0; y = '0; min_count = '0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (2) applyStimulus(0, 0, 0, '0, '0);

    for (int v = 0; v < 7; v++) runVec(vecs[v]);

    // Second frame end ten cycles into a division.
    min_count = 32'd1;
    applyStimulus(1, 0, 0, '0, '0);
    applyStimulus(1, 1, 1, 10'd100, 10'd50);
    applyStimulus(0, 0, 0, '0, '0);
    frameEnd = cycleNum;
    pushResult(frameEnd + LAT, 1'b1, 10'd100, 10'd50, 32'd1);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1, 1, 1, 10'd200, 10'd200);
      if (i == 5) checkOutput("busyDuringDiv", busy, 1);
    end
    ovrQ.push_back(frameEnd + 10);
    applyStimulus(0, 0, 0, '0, '0);
    waitResults();
    repeat (80) applyStimulus(0, 0, 0, '0, '0);
    checkOutput("overrunDrained", ovrQ.size(), 0);

    // Frame end landing exactly in the DONE cycle.
    applyStimulus(1, 0, 0, '0, '0);
    applyStimulus(1, 1, 1, 10'd100, 10'd50);
    applyStimulus(0, 0, 0, '0, '0);
    frameEnd = cycleNum;
    pushResult(frameEnd + LAT, 1'b1, 10'd100, 10'd50, 32'd1);
    for (int i = 1; i < LAT; i++) applyStimulus(1, 1, 1, 10'd300, 10'd300);
    ovrQ.push_back(frameEnd + LAT);
    applyStimulus(0, 0, 0, '0, '0);
    waitResults();
    repeat (80) applyStimulus(0, 0, 0, '0, '0);
    checkOutput("doneOverrunDrained", ovrQ.size(), 0);

    // Reset in the middle of a division abandons the result.
    applyStimulus(1, 0, 0, '0, '0);
    applyStimulus(1, 1, 1, 10'd40, 10'd60);
    applyStimulus(0, 0, 0, '0, '0);
    frameEnd = cycleNum;
    pushResult(frameEnd + LAT, 1'b1, 10'd40, 10'd60, 32'd1);
    for (int i = 1; i < 20; i++) applyStimulus(0, 0, 0, '0, '0);
    checkOutput("busyBeforeReset", busy, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    resQ.delete();
    #1;
    checkAllZero("midReset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) applyStimulus(0, 0, 0, '0, '0);
    runVec(vecs[6]);

    checkOutput("resultQueueEmpty", resQ.size(), 0);
    checkOutput("overrunQueueEmpty", ovrQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
